// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    GAP
  } st_e;

  // Index width that stays at least one bit even for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request after 'last'.
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   win,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_tx_data,
  input  logic [DATA_W-1:0]         spi_rx_data,
  input  logic                      spi_done
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int GAP_W = idx_w(GAP_CYCLES + 1);

  st_e                state_q;
  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [DATA_W-1:0]  tx_q;
  logic               busy_q;
  logic               start_q;
  logic [GAP_W-1:0]   gap_q;

  logic [IDX_W-1:0]   pick_win;
  logic               pick_any;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wcnt_q;
  logic            rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req (req),
    .last(last_q),
    .win (pick_win),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tx_q        <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      gap_q       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            last_q  <= pick_win;
            tx_q    <= req_data[int'(pick_win)*DATA_W +: DATA_W];
            gnt_q   <= NUM_REQ'(1) << pick_win;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
        end
        WAIT: begin
          if (spi_done) begin
            rsp_valid_q <= gnt_q;
            rsp_data_q  <= spi_rx_data;
            state_q     <= RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (wcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expiry: answer the winner with an error and no data.
            rsp_valid_q <= gnt_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            wcnt_q <= wcnt_q + TO_W'(1);
`endif
          end
        end
        RESP: begin
          gnt_q <= '0;
          gap_q <= '0;
          if (GAP_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (int'(gap_q) == GAP_CYCLES - 1) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign spi_start   = start_q;
  assign spi_tx_data = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a reference round-robin model and SPI master model.
module tb_spi_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW-1:0]   rsp_data, spi_tx_data;
  logic            rsp_err, busy, spi_start;
  logic [DW-1:0]   spi_rx_data = '0;
  logic            spi_done = 1'b0;

  spi_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct { int win; logic [DW-1:0] data; } start_t;
  typedef struct { int win; logic [DW-1:0] data; logic err; int at; } rsp_t;

  start_t start_q[$];
  rsp_t   rsp_q[$];

  int            model_last = N - 1;
  int            n_start = 0;
  int            n_rsp = 0;
  int            last_start_cyc = -1;
  bit            chk_spacing = 1'b0;
  int            m_delay = 0;
  bit            m_enable = 1'b1;
  bit            m_fix_en = 1'b0;
  logic [DW-1:0] m_fix = '0;
  int            epoch = 0;
  int            cur_win = -1;
  logic [DW-1:0] cur_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first pending requester after the previous winner.
  function automatic int pick(input logic [N-1:0] mask, input int last);
    for (int off = 1; off <= N; off++)
      if (mask[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic expect_txn(input logic [N-1:0] mask);
    int w;
    w = pick(mask, model_last);
    model_last = w;
    start_q.push_back('{win: w, data: req_data[w*DW +: DW]});
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k;
    k = 0;
    while (n_rsp < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (n_rsp < target) begin
      errors++;
      $display("FAIL wait_rsp: got %0d responses, required %0d", n_rsp, target);
    end
  endtask

  task automatic wait_start(input int target, input int budget);
    int k;
    k = 0;
    while (n_start < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (n_start < target) begin
      errors++;
      $display("FAIL wait_start: got %0d starts, required %0d", n_start, target);
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset_n = 1'b0;
    epoch++;
    start_q.delete();
    model_last = N - 1;
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon_start
    start_t e;
    int prev;
    if (reset_n && spi_start) begin
      n_start++;
      prev = last_start_cyc;
      last_start_cyc = cyc;
      if (start_q.size() == 0) begin
        checks++;
        errors++;
        cur_win = -1;
        $display("FAIL unexpected_start: gnt=0x%0h, required no start", gnt);
      end else begin
        e = start_q.pop_front();
        cur_win = e.win;
        cur_data = e.data;
        check("start_gnt", 64'(gnt), 64'(N'(1) << e.win));
        check("start_tx", 64'(spi_tx_data), 64'(e.data));
        check("start_busy", 64'(busy), 64'd1);
      end
      if (chk_spacing && prev >= 0) check("start_spacing", 64'(cyc - prev), 64'(4 + GAP));
    end
  end

  always @(negedge clk) begin : master
    int ep;
    int w;
    logic [DW-1:0] rx;
    logic [DW-1:0] d;
    if (reset_n && spi_start && m_enable) begin
      #1;
      ep = epoch;
      w = cur_win;
      d = cur_data;
      rx = m_fix_en ? m_fix : DW'($urandom);
      repeat (m_delay + 1) @(posedge clk);
      #1;
      if (ep == epoch && reset_n && w >= 0) begin
        check("wait_gnt_held", 64'(gnt), 64'(N'(1) << w));
        check("wait_tx_held", 64'(spi_tx_data), 64'(d));
        check("wait_busy", 64'(busy), 64'd1);
        spi_rx_data = rx;
        spi_done = 1'b1;
        rsp_q.push_back('{win: w, data: rx, err: 1'b0, at: cyc + 1});
        @(posedge clk); #1;
        spi_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (reset_n && rsp_valid != '0) begin
      n_rsp++;
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=0x%0h, required none", rsp_valid);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.win));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_gnt", 64'(gnt), 64'(N'(1) << e.win));
        check("rsp_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  always @(posedge clk) begin
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d, limit 20000", cyc);
      $fatal(1, "bench watchdog expired");
    end
  end

  initial begin
    int base;
    logic [N-1:0] mask;

    repeat (3) @(negedge clk);
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_spi_start", 64'(spi_start), 64'd0);
    check("reset_spi_tx", 64'(spi_tx_data), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request with fixed bytes.
    req_data[0 +: DW] = 8'hA5;
    m_fix_en = 1'b1; m_fix = 8'h3C; m_delay = 16;
    expect_txn(4'b0001);
    base = n_rsp;
    req = 4'b0001;
    wait_rsp(base + 1, 200);
    req = '0; m_fix_en = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Fairness with all requesters held, master answering immediately.
    do_reset(2);
    repeat (2) @(negedge clk);
    rand_data();
    m_delay = 0;
    last_start_cyc = -1;
    chk_spacing = 1'b1;
    for (int i = 0; i < 5; i++) expect_txn(4'b1111);
    base = n_rsp;
    req = 4'b1111;
    wait_rsp(base + 5, 300);
    req = '0;
    chk_spacing = 1'b0;
    repeat (6) @(negedge clk);

    // Skip: make requester 1 the last winner, then 1010 gives 3 then 1.
    rand_data();
    m_delay = 2;
    expect_txn(4'b0010);
    base = n_rsp;
    req = 4'b0010;
    wait_rsp(base + 1, 200);
    req = '0;
    repeat (6) @(negedge clk);
    rand_data();
    expect_txn(4'b1010);
    expect_txn(4'b1010);
    base = n_rsp;
    req = 4'b1010;
    wait_rsp(base + 2, 300);
    req = '0;
    repeat (6) @(negedge clk);

    // Requester 2 drops during WAIT; requester 0 follows.
    rand_data();
    m_delay = 10;
    expect_txn(4'b0100);
    base = n_rsp;
    req = 4'b0100;
    wait_start(n_start + 1, 100);
    repeat (3) @(negedge clk);
    req = 4'b0001;
    expect_txn(4'b0001);
    wait_rsp(base + 2, 300);
    req = '0;
    repeat (6) @(negedge clk);

    // Stray done pulse while idle must be ignored.
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_done_busy", 64'(busy), 64'd0);

    // Randomized rounds, some requests landing in the gap.
    for (int r = 0; r < 20; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      rand_data();
      m_delay = $urandom_range(0, 6);
      expect_txn(mask);
      base = n_rsp;
      req = mask;
      wait_rsp(base + 1, 200);
      req = '0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    repeat (6) @(negedge clk);

    // Reset in the middle of WAIT.
    rand_data();
    m_delay = 30;
    expect_txn(4'b0100);
    req = 4'b0100;
    wait_start(n_start + 1, 100);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    epoch++;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_spi_start", 64'(spi_start), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    start_q.delete();
    model_last = N - 1;
    req = 4'b0101;
    rand_data();
    m_delay = 1;
    repeat (35) @(negedge clk);
    expect_txn(4'b0101);
    expect_txn(4'b0101);
    base = n_rsp;
    reset_n = 1'b1;
    wait_rsp(base + 2, 300);
    req = '0;
    repeat (6) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never answers: watchdog response after TO cycles in WAIT.
    m_enable = 1'b0;
    rand_data();
    expect_txn(4'b0001);
    base = n_rsp;
    req = 4'b0001;
    wait_start(n_start + 1, 100);
    rsp_q.push_back('{win: 0, data: '0, err: 1'b1, at: last_start_cyc + 1 + TO});
    wait_rsp(base + 1, TO + 50);
    req = '0;
    m_enable = 1'b1;
    repeat (6) @(negedge clk);
`else
    // Master never answers: arbiter stays busy in WAIT.
    m_enable = 1'b0;
    rand_data();
    expect_txn(4'b0001);
    base = n_rsp;
    req = 4'b0001;
    wait_start(n_start + 1, 100);
    repeat (100) @(negedge clk);
    check("hang_busy", 64'(busy), 64'd1);
    check("hang_no_rsp", 64'(n_rsp), 64'(base));
    req = '0;
    do_reset(2);
    m_enable = 1'b1;
    repeat (4) @(negedge clk);
`endif

    check("start_queue_drained", 64'(start_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
